receiver_ic: RTL and testbench

- Receiving end of the Request/Ack word-transfer link driven by sender_ic.
- Accepts 16-bit words one per handshake into a DEPTH-entry frame buffer, starting at address 0 and incrementing.
- Flags frame completion after DEPTH words.
- Exposes buffer contents to downstream logic through a registered read port.
- Same clock domain as the sender; no synchronisers.

---
 rtl/pcid_link_pkg.sv | 12 +
 rtl/receiver_mem.sv | 42 ++++
 rtl/receiver_ic.sv | 118 +++++++++++
 tb/tb_receiver_ic.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcid_link_pkg.sv
// Definitions shared by both ends of the Request/Ack word-transfer link.
package pcid_link_pkg;

    localparam int PCID_DATA_WIDTH = 16;
    localparam int PCID_DEPTH      = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/receiver_mem.sv
// Frame buffer: DEPTH x DATA_WIDTH register file with one write port,
// one registered read port and asynchronous clear.
module receiver_mem #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array; cleared on reset, one word written per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; a write to the same address this cycle returns the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/receiver_ic.sv
// Receiving end of the Request/Ack link: captures one word per four-phase
// handshake into the frame buffer and tracks frame completion.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for Request; a Request (without start) captures a word
//  ST_ACK  | word captured, Ack held high until the sender drops Request
module receiver_ic
    import pcid_link_pkg::*;
#(
    parameter int DATA_WIDTH = PCID_DATA_WIDTH,
    parameter int DEPTH      = PCID_DEPTH,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic                  Request,
    input  logic [DATA_WIDTH-1:0] rcvDataIn,
    output logic                  Ack,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  frameDone,
    output logic                  frameValid,
    output logic [ADDR_WIDTH:0]   wordCount
);

    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

    rx_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  wr_en;

    // State, pointer and frame-status registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    // Handshake FSM and capture bookkeeping; start overrides pointer/count
    // but leaves the handshake state alone.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        wr_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Request && !start) begin
                    wr_en    = 1'b1;
                    // DEPTH is a power of two, so the natural overflow wraps to 0.
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    state_d  = ST_ACK;
                    if (cnt_q == CNT_FULL) begin
                        cnt_d   = CNT_ONE;
                        valid_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            valid_d = 1'b1;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            ST_ACK: begin
                if (!Request) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        if (start) begin
            wr_ptr_d = '0;
            cnt_d    = '0;
            valid_d  = 1'b0;
        end
    end

    receiver_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .rst_n  (Reset),
        .we_i   (wr_en),
        .waddr_i(wr_ptr_q),
        .wdata_i(rcvDataIn),
        .raddr_i(rdAddr),
        .rdata_o(rdData)
    );

    assign Ack        = (state_q == ST_ACK);
    assign frameDone  = done_q;
    assign frameValid = valid_q;
    assign wordCount  = cnt_q;

endmodule

// File: tb/tb_receiver_ic.sv
// Self-checking bench for receiver_ic: reference model tracked per clock edge,
// fixed vector table, directed corner sequences and a random protocol phase.
module tb_receiver_ic;

    logic        clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        Request;
    logic [15:0] rcvDataIn;
    logic        Ack;
    logic [3:0]  rdAddr;
    logic [15:0] rdData;
    logic        frameDone;
    logic        frameValid;
    logic [4:0]  wordCount;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;
    int ack_hi_cnt = 0;

    // reference model: buffer contents and frame bookkeeping
    logic [15:0] m_mem [16];
    int          m_ptr, m_cnt;
    bit          m_valid, m_ack, m_done;
    logic [15:0] m_rd;

    typedef struct {
        bit          st;
        bit          rq;
        logic [15:0] d;
        logic [3:0]  ra;
        bit          e_ack;
        int          e_cnt;
        bit          e_valid;
        bit          e_done;
        logic [15:0] e_rd;
    } vec_t;
    vec_t vt [4];

    receiver_ic dut (
        .clk       (clk),
        .Reset     (Reset),
        .start     (start),
        .Request   (Request),
        .rcvDataIn (rcvDataIn),
        .Ack       (Ack),
        .rdAddr    (rdAddr),
        .rdData    (rdData),
        .frameDone (frameDone),
        .frameValid(frameValid),
        .wordCount (wordCount)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h req=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_ptr = 0; m_cnt = 0; m_valid = 0; m_ack = 0; m_done = 0; m_rd = '0;
    endtask

    // One rising edge as seen from the link rules.
    task automatic model_edge();
        m_rd   = m_mem[rdAddr];
        m_done = 0;
        if (m_ack) begin
            if (!Request) m_ack = 0;
        end else if (Request && !start) begin
            m_mem[m_ptr] = rcvDataIn;
            m_ptr = (m_ptr + 1) % 16;
            m_ack = 1;
            if (m_cnt == 16) begin
                m_cnt = 1;
                m_valid = 0;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == 16) begin
                    m_valid = 1;
                    m_done = 1;
                end
            end
        end
        if (start) begin
            m_ptr = 0; m_cnt = 0; m_valid = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("ack", int'(Ack), int'(m_ack));
        chk("frameDone", int'(frameDone), int'(m_done));
        chk("frameValid", int'(frameValid), int'(m_valid));
        chk("wordCount", int'(wordCount), m_cnt);
        chk("rdData", int'(rdData), int'(m_rd));
        if (frameDone) done_seen++;
        if (Request && Ack) ack_hi_cnt++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input int hold);
        int n;
        Request = 1'b1;
        rcvDataIn = d;
        n = 0;
        while (!Ack && n < 8) begin
            step();
            n++;
        end
        chk("ack_rise_latency", n, 1);
        repeat (hold) step();
        Request = 1'b0;
        n = 0;
        while (Ack && n < 8) begin
            step();
            n++;
        end
        chk("ack_fall_latency", n, 1);
    endtask

    task automatic read_chk(input int a, input logic [15:0] exp);
        rdAddr = 4'(a);
        step();
        chk("mem_read", int'(rdData), int'(exp));
    endtask

    initial begin
        int base;
        Reset = 1'b0; start = 1'b0; Request = 1'b0; rcvDataIn = '0; rdAddr = '0;
        model_reset();

        // reset state
        repeat (5) @(negedge clk);
        chk("rst_ack", int'(Ack), 0);
        chk("rst_valid", int'(frameValid), 0);
        chk("rst_count", int'(wordCount), 0);
        chk("rst_done", int'(frameDone), 0);
        Reset = 1'b1;
        for (int i = 0; i < 16; i++) read_chk(i, 16'h0000);

        // single word, table-driven
        vt[0] = '{st:0, rq:1, d:16'hA5A5, ra:4'd0, e_ack:1, e_cnt:1, e_valid:0, e_done:0, e_rd:16'h0000};
        vt[1] = '{st:0, rq:1, d:16'hA5A5, ra:4'd0, e_ack:1, e_cnt:1, e_valid:0, e_done:0, e_rd:16'hA5A5};
        vt[2] = '{st:0, rq:0, d:16'h0000, ra:4'd0, e_ack:0, e_cnt:1, e_valid:0, e_done:0, e_rd:16'hA5A5};
        vt[3] = '{st:0, rq:0, d:16'h0000, ra:4'd1, e_ack:0, e_cnt:1, e_valid:0, e_done:0, e_rd:16'h0000};
        for (int i = 0; i < 4; i++) begin
            start = vt[i].st; Request = vt[i].rq; rcvDataIn = vt[i].d; rdAddr = vt[i].ra;
            step();
            chk("vec_ack", int'(Ack), int'(vt[i].e_ack));
            chk("vec_count", int'(wordCount), vt[i].e_cnt);
            chk("vec_valid", int'(frameValid), int'(vt[i].e_valid));
            chk("vec_done", int'(frameDone), int'(vt[i].e_done));
            chk("vec_rd", int'(rdData), int'(vt[i].e_rd));
        end

        // full frame
        pulse_start();
        chk("start_count", int'(wordCount), 0);
        base = done_seen;
        for (int i = 0; i < 16; i++) begin
            send_word(16'h1000 + 16'(i), 0);
            if (i == 14) chk("done_early", done_seen - base, 0);
        end
        chk("done_pulses", done_seen - base, 1);
        chk("full_valid", int'(frameValid), 1);
        chk("full_count", int'(wordCount), 16);
        for (int i = 0; i < 16; i++) read_chk(i, 16'h1000 + 16'(i));

        // long Request: one capture, Ack high throughout
        pulse_start();
        ack_hi_cnt = 0;
        send_word(16'hBEEF, 9);
        chk("long_count", int'(wordCount), 1);
        chk("long_ack_cycles", ack_hi_cnt, 10);
        read_chk(0, 16'hBEEF);
        read_chk(1, 16'h1001);

        // start mid-frame
        pulse_start();
        for (int i = 0; i < 5; i++) send_word(16'h3000 + 16'(i), 0);
        chk("mid_count5", int'(wordCount), 5);
        pulse_start();
        send_word(16'h2222, 0);
        chk("mid_count", int'(wordCount), 1);
        chk("mid_valid", int'(frameValid), 0);
        read_chk(0, 16'h2222);
        for (int i = 1; i < 5; i++) read_chk(i, 16'h3000 + 16'(i));

        // complete frame, then a 17th word begins a new frame
        pulse_start();
        for (int i = 0; i < 16; i++) send_word(16'h5000 + 16'(i), 0);
        chk("f2_valid", int'(frameValid), 1);
        send_word(16'h6666, 0);
        chk("w17_valid", int'(frameValid), 0);
        chk("w17_count", int'(wordCount), 1);
        read_chk(0, 16'h6666);

        // start colliding with a rising Request
        start = 1'b1; Request = 1'b1; rcvDataIn = 16'h4444; rdAddr = 4'd0;
        step();
        chk("coll_ack_held", int'(Ack), 0);
        chk("coll_count0", int'(wordCount), 0);
        start = 1'b0;
        step();
        chk("coll_ack", int'(Ack), 1);
        chk("coll_count1", int'(wordCount), 1);
        Request = 1'b0;
        step();
        read_chk(0, 16'h4444);

        // reset in the middle of a handshake
        Request = 1'b1; rcvDataIn = 16'h7777;
        step();
        chk("mid_rst_ack_pre", int'(Ack), 1);
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_ack", int'(Ack), 0);
        chk("mid_rst_count", int'(wordCount), 0);
        model_reset();
        @(negedge clk);
        Reset = 1'b1;
        step();
        chk("post_rst_ack", int'(Ack), 1);
        chk("post_rst_count", int'(wordCount), 1);
        Request = 1'b0;
        step();
        read_chk(0, 16'h7777);

        // random protocol-following traffic against the model
        for (int k = 0; k < 800; k++) begin
            start  = ($urandom_range(0, 31) == 0);
            rdAddr = 4'($urandom_range(0, 15));
            if (!Request && !m_ack && $urandom_range(0, 2) != 0) begin
                Request = 1'b1;
                rcvDataIn = 16'($urandom);
            end else if (Request && m_ack && $urandom_range(0, 1) == 0) begin
                Request = 1'b0;
            end
            step();
        end
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
